// File: rtl/mips_mmio_display.sv
// -----------------------------------------------------------------------------
// mips_mmio_display
//
// Memory-mapped display/LED responder for the MIPS data bus. It decodes a
// 16-byte window at BASE_ADDR and holds the registers listed below. It also
// scans a 4-digit multiplexed 7-segment display and drives the board LEDs.
//
// Register map (offset = MemAddr[3:2]):
//   0x0 VALUE  [15:0] RW, four hex nibbles; digit i shows VALUE[4i+3:4i]
//   0x4 LEDR   [9:0]  RW, copied to LED one cycle after it is written
//   0x8 CTRL   [3:0]  RW digit enable, [7:4] decimal points (MMIO_DP_EN only)
//   0xC STATUS RO     [1:0] current digit index, [31:16] frame count
//
// Ports:
//   clk        in   1   system clock; all state changes on posedge
//   reset      in   1   synchronous, active-high; dominates MemWrite
//   MemWrite   in   1   write strobe, one word per cycle
//   MemAddr    in   32  byte address ([1:0] ignored)
//   MemWData   in   32  write data
//   MemRData   out  32  combinational read data (0 outside the window)
//   hit        out  1   combinational: MemAddr is inside the window
//   HEX        out  8   segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   HEX_DIGIT  out  4   one-hot active-low digit select, registered
//   LED        out  10  LED drive, active-high, registered
//
// Configuration macro: MMIO_DP_EN
//   defined   : CTRL[7:4] is stored and drives the decimal point (HEX[7])
//   undefined : CTRL[7:4] reads 0 and HEX[7] is always 1 (dp off)
// -----------------------------------------------------------------------------
module mips_mmio_display #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int          SCAN_DIV  = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] MemAddr,
   input  logic [31:0] MemWData,
   output logic [31:0] MemRData,
   output logic        hit,
   output logic [7:0]  HEX,
   output logic [3:0]  HEX_DIGIT,
   output logic [9:0]  LED
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [15:0]      r_value;
   logic [9:0]       r_ledr;
   logic [3:0]       r_en;
`ifdef MMIO_DP_EN
   logic [3:0]       r_dp;
`endif
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_idx;
   logic [15:0]      r_frame;
   logic [7:0]       r_hex;
   logic [3:0]       r_hex_digit;
   logic [9:0]       r_led;

   logic        w_hit;
   logic        w_wr;
   logic [1:0]  w_sel;
   logic [31:0] w_ctrl_rd;
   logic [3:0]  w_nib;
   logic        w_dp_cur;
   logic        w_unused_bits;

   // Standard hex glyphs, active-high {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         default: seg7 = 7'h71;
      endcase
   endfunction

   assign w_hit = (MemAddr[31:4] == BASE_ADDR[31:4]);
   assign w_wr  = MemWrite && w_hit;
   assign w_sel = MemAddr[3:2];
   assign w_nib = r_value[{r_idx, 2'b00} +: 4];

`ifdef MMIO_DP_EN
   assign w_ctrl_rd = {24'h0, r_dp, r_en};
   assign w_dp_cur  = r_dp[r_idx];
`else
   assign w_ctrl_rd = {28'h0, r_en};
   assign w_dp_cur  = 1'b0;
`endif

   // Byte-lane bits and upper data bits have no storage behind them.
   assign w_unused_bits = ^{MemAddr[1:0], MemWData[31:16]};

   // Async read, like the data RAM: a write in this cycle is not yet visible.
   always_comb begin
      MemRData = 32'h0;
      if (w_hit) begin
         case (w_sel)
            2'd0:    MemRData = {16'h0, r_value};
            2'd1:    MemRData = {22'h0, r_ledr};
            2'd2:    MemRData = w_ctrl_rd;
            default: MemRData = {r_frame, 14'h0, r_idx};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value     <= '0;
         r_ledr      <= '0;
         r_en        <= 4'hF;
`ifdef MMIO_DP_EN
         r_dp        <= '0;
`endif
         r_div       <= '0;
         r_idx       <= '0;
         r_frame     <= '0;
         // Digit 0 enabled showing '0' with dp off.
         r_hex       <= 8'hC0;
         r_hex_digit <= 4'b1110;
         r_led       <= '0;
      end else begin
         if (w_wr) begin
            case (w_sel)
               2'd0: r_value <= MemWData[15:0];
               2'd1: r_ledr  <= MemWData[9:0];
               2'd2: begin
                  r_en <= MemWData[3:0];
`ifdef MMIO_DP_EN
                  r_dp <= MemWData[7:4];
`endif
               end
               default: ; // STATUS is read-only
            endcase
         end

         // Slot timer; each wrap moves to the next digit, digit 3->0 ends a frame.
         if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_frame <= r_frame + 16'd1;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end

         // Outputs reflect current (pre-edge) index and register contents.
         r_led <= r_ledr;
         if (r_en[r_idx]) begin
            r_hex_digit <= ~(4'b0001 << r_idx);
            r_hex       <= ~{w_dp_cur, seg7(w_nib)};
         end else begin
            r_hex_digit <= 4'hF;
            r_hex       <= 8'hFF;
         end
      end
   end

   assign hit       = w_hit;
   assign HEX       = r_hex;
   assign HEX_DIGIT = r_hex_digit;
   assign LED       = r_led;

endmodule

// File: tb/tb_mips_mmio_display.sv
// -----------------------------------------------------------------------------
// tb_mips_mmio_display
//
// Directed bench for mips_mmio_display with SCAN_DIV=4. A table of bus
// vectors covers decode, read-back and LED latency; hand-written sequences
// cover scan timing, writes coinciding with a digit advance, mid-scan reset
// and the decimal-point option.
// -----------------------------------------------------------------------------
module tb_mips_mmio_display;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        hit;
   logic [7:0]  HEX;
   logic [3:0]  HEX_DIGIT;
   logic [9:0]  LED;

   int n_checks = 0;
   int n_fail   = 0;
   int tb_cyc   = 0;

   // Shadow of the programmed registers, used to build display expectations.
   logic [15:0] m_value;
   logic [3:0]  m_en;
   logic [3:0]  m_dp;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic        exp_hit;
      logic [31:0] exp_rd;
      logic [9:0]  exp_led;
   } vec_t;

   vec_t vecs [14];

   mips_mmio_display #(
      .BASE_ADDR (32'hFFFF_0000),
      .SCAN_DIV  (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemAddr   (MemAddr),
      .MemWData  (MemWData),
      .MemRData  (MemRData),
      .hit       (hit),
      .HEX       (HEX),
      .HEX_DIGIT (HEX_DIGIT),
      .LED       (LED)
   );

   // ---------------- clock / reset-relative cycle count ----------------
   always #5 clk = ~clk;

   // Posedges since the last reset edge; the scan position follows from it.
   always @(posedge clk) begin
      if (reset) tb_cyc <= 0;
      else       tb_cyc <= tb_cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_hex(input int d);
      if (!m_en[d]) return 8'hFF;
      return ~{m_dp[d], seg_tab[m_value[4*d +: 4]]};
   endfunction

   function automatic logic [3:0] exp_dig(input int d);
      if (!m_en[d]) return 4'hF;
      return ~(4'b0001 << d);
   endfunction

   // Output after posedge k reflects the digit selected after posedge k-1.
   task automatic check_display(input string tag);
      int d;
      d = ((tb_cyc - 1) / 4) % 4;
      chk({tag, "_hex"}, {24'h0, HEX}, {24'h0, exp_hex(d)});
      chk({tag, "_digit"}, {28'h0, HEX_DIGIT}, {28'h0, exp_dig(d)});
   endtask

   task automatic check_status(input string tag);
      logic [31:0] exp;
      @(negedge clk);
      MemWrite = 1'b0;
      MemAddr  = 32'hFFFF_000C;
      #1;
      exp = {16'(tb_cyc / 16), 14'h0, 2'((tb_cyc / 4) % 4)};
      chk(tag, MemRData, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         MemWrite = 1'b0;
         MemAddr  = 32'h0;
      end
   endtask

   // Wait (bounded) until the coming posedge is a digit advance.
   task automatic wait_advance(input string tag);
      bit found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
         @(negedge clk);
         MemWrite = 1'b0;
         if (tb_cyc % 4 == 3) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no digit advance seen within 8 cycles", tag);
      end
   endtask

   // Write landing on the same edge as a digit advance: old contents shown for
   // that edge, new contents from the next one.
   task automatic adv_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      int          i;
      logic [7:0]  e1_hex, e2_hex;
      logic [3:0]  e1_dig, e2_dig;
      wait_advance(tag);
      i      = (tb_cyc / 4) % 4;
      e1_hex = exp_hex(i);
      e1_dig = exp_dig(i);
      MemWrite = 1'b1;
      MemAddr  = a;
      MemWData = d;
      if (a[3:2] == 2'd0) m_value = d[15:0];
      if (a[3:2] == 2'd2) begin
         m_en = d[3:0];
`ifdef MMIO_DP_EN
         m_dp = d[7:4];
`endif
      end
      e2_hex = exp_hex((i + 1) % 4);
      e2_dig = exp_dig((i + 1) % 4);
      @(negedge clk);
      MemWrite = 1'b0;
      chk({tag, "_old_hex"}, {24'h0, HEX}, {24'h0, e1_hex});
      chk({tag, "_old_digit"}, {28'h0, HEX_DIGIT}, {28'h0, e1_dig});
      @(negedge clk);
      chk({tag, "_new_hex"}, {24'h0, HEX}, {24'h0, e2_hex});
      chk({tag, "_new_digit"}, {28'h0, HEX_DIGIT}, {28'h0, e2_dig});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      //          we    addr           wdata          chk  hit  rdata          led
      vecs[0]  = '{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 1'b1, 32'h0,         10'h000};
      vecs[1]  = '{1'b0, 32'hFFFF_0004, 32'h0,         1'b1, 1'b1, 32'h0,         10'h000};
      vecs[2]  = '{1'b0, 32'hFFFF_0008, 32'h0,         1'b1, 1'b1, 32'hF,         10'h000};
      vecs[3]  = '{1'b1, 32'hFFFF_0000, 32'h1234_ABCD, 1'b1, 1'b1, 32'h0,         10'h000};
      vecs[4]  = '{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 1'b1, 32'h0000_ABCD, 10'h000};
      vecs[5]  = '{1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         10'h000};
      vecs[6]  = '{1'b0, 32'hFFFF_0004, 32'h0,         1'b1, 1'b1, 32'h3FF,       10'h000};
      vecs[7]  = '{1'b1, 32'hFFFF_000C, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         10'h3FF};
      vecs[8]  = '{1'b1, 32'hFFFF_0010, 32'h0,         1'b1, 1'b0, 32'h0,         10'h3FF};
      vecs[9]  = '{1'b0, 32'hFFFF_0003, 32'h0,         1'b1, 1'b1, 32'h0000_ABCD, 10'h3FF};
      vecs[10] = '{1'b1, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h0,         10'h3FF};
      vecs[11] = '{1'b0, 32'hFFFE_0008, 32'h0,         1'b1, 1'b0, 32'h0,         10'h3FF};
      vecs[12] = '{1'b0, 32'hFFFF_0004, 32'h0,         1'b1, 1'b1, 32'h3FF,       10'h3FF};
      vecs[13] = '{1'b0, 32'hFFFF_0008, 32'h0,         1'b1, 1'b1, 32'hF,         10'h3FF};

      m_value = 16'h0;
      m_en    = 4'hF;
      m_dp    = 4'h0;

      // Reset held for three edges.
      reset    = 1'b1;
      MemWrite = 1'b0;
      MemAddr  = 32'h0;
      MemWData = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_hex", {24'h0, HEX}, 32'hC0);
      chk("reset_digit", {28'h0, HEX_DIGIT}, 32'hE);
      chk("reset_led", {22'h0, LED}, 32'h0);
      reset = 1'b0;

      // Bus vectors: read data is the pre-write value of the addressed register.
      for (int v = 0; v < 14; v++) begin
         @(negedge clk);
         MemWrite = vecs[v].we;
         MemAddr  = vecs[v].addr;
         MemWData = vecs[v].wdata;
         #1;
         chk($sformatf("vec%0d_hit", v), {31'h0, hit}, {31'h0, vecs[v].exp_hit});
         if (vecs[v].chk_rd) chk($sformatf("vec%0d_rdata", v), MemRData, vecs[v].exp_rd);
         chk($sformatf("vec%0d_led", v), {22'h0, LED}, {22'h0, vecs[v].exp_led});
      end
      m_value = 16'hABCD;

      // Scan with all digits enabled: D,C,B,A across 4-cycle slots.
      check_status("status_a");
      idle(1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_display($sformatf("scan_c%0d", c));
      end

      // Writes coinciding with a digit advance.
      adv_write("adv_value", 32'hFFFF_0000, 32'h0000_5555);
      adv_write("adv_ctrl", 32'hFFFF_0008, 32'h0000_0005);

      // Digits 1 and 3 blanked, 0 and 2 still driven.
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check_display($sformatf("ctrl5_c%0d", c));
      end

      // Let two more frames elapse and check the frame counter.
      idle(32);
      check_status("status_frames");

      // Reset in the middle of digit 2's slot with a write alongside.
      begin
         bit found = 1'b0;
         for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            MemWrite = 1'b0;
            if (tb_cyc % 16 == 9) found = 1'b1;
         end
         if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL midreset_wait: digit 2 slot not reached in 20 cycles");
         end
      end
      reset    = 1'b1;
      MemWrite = 1'b1;
      MemAddr  = 32'hFFFF_0000;
      MemWData = 32'h0000_7777;
      @(negedge clk);
      reset    = 1'b0;
      MemWrite = 1'b0;
      m_value  = 16'h0;
      m_en     = 4'hF;
      m_dp     = 4'h0;
      #1;
      chk("midreset_hex", {24'h0, HEX}, 32'hC0);
      chk("midreset_digit", {28'h0, HEX_DIGIT}, 32'hE);
      chk("midreset_led", {22'h0, LED}, 32'h0);
      chk("midreset_status", MemRData, 32'h0);
      MemAddr = 32'hFFFF_0000;
      #1;
      chk("midreset_value", MemRData, 32'h0);
      MemAddr = 32'hFFFF_0008;
      #1;
      chk("midreset_ctrl", MemRData, 32'hF);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_display($sformatf("postreset_c%0d", c));
      end

      // Decimal-point field of CTRL.
      @(negedge clk);
      MemWrite = 1'b1;
      MemAddr  = 32'hFFFF_0008;
      MemWData = 32'h0000_001F;
      @(negedge clk);
      MemWrite = 1'b0;
      #1;
`ifdef MMIO_DP_EN
      chk("ctrl_dp_read", MemRData, 32'h1F);
      m_dp = 4'h1;
`else
      chk("ctrl_dp_read", MemRData, 32'hF);
`endif
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check_display($sformatf("dp_c%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
